viterbi_acs_scheduler: RTL



---
 rtl/viterbi_acs_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/viterbi_acs_scheduler.sv
// viterbi_acs_scheduler: sequences per-symbol ACS sweeps over all
// trellis states, then a backward survivor traceback per frame.
module viterbi_acs_scheduler #(
  parameter int SW        = 6,
  parameter int FRAME_LEN = 32,
  parameter int STEP_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic [SW-1:0]     acs_idx,
  output logic              acs_en,
  output logic [STEP_W-1:0] step_cnt,
  output logic [STEP_W-1:0] tb_addr,
  output logic [SW-1:0]     tb_state,
  input  logic              surv_bit,
  output logic              dec_bit,
  output logic              dec_valid,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACS,
    TB,
    DONE
  } state_t;

  localparam logic [SW-1:0]     IDX_LAST  = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAME_LEN - 1);

  state_t state, state_d;

  logic              sym_ready_d;
  logic [SW-1:0]     acs_idx_d;
  logic              acs_en_d;
  logic [STEP_W-1:0] step_cnt_d;
  logic [STEP_W-1:0] tb_addr_d;
  logic [SW-1:0]     tb_state_d;
  logic              dec_bit_d;
  logic              dec_valid_d;
  logic              frame_done_d;
  logic              busy_d;

  always_comb begin
    state_d      = state;
    sym_ready_d  = sym_ready;
    acs_idx_d    = acs_idx;
    acs_en_d     = acs_en;
    step_cnt_d   = step_cnt;
    tb_addr_d    = tb_addr;
    tb_state_d   = tb_state;
    dec_bit_d    = dec_bit;
    dec_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (sym_valid && sym_ready) begin
          state_d     = ACS;
          acs_idx_d   = '0;
          acs_en_d    = 1'b1;
          sym_ready_d = 1'b0;
        end
      end

      ACS: begin
        if (acs_idx == IDX_LAST) begin
          acs_idx_d = '0;
          acs_en_d  = 1'b0;
          if (step_cnt == STEP_LAST) begin
            state_d    = TB;
            tb_addr_d  = STEP_LAST;
            tb_state_d = '0;
          end else begin
            state_d     = IDLE;
            step_cnt_d  = step_cnt + 1'b1;
            sym_ready_d = 1'b1;
          end
        end else begin
          acs_idx_d = acs_idx + 1'b1;
        end
      end

      // The survivor bit becomes the new MSB of the predecessor state;
      // the bit shifted out is the decoded input for this step.
      TB: begin
        dec_bit_d   = tb_state[0];
        dec_valid_d = 1'b1;
        tb_state_d  = {surv_bit, tb_state[SW-1:1]};
        if (tb_addr == '0) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          tb_addr_d = tb_addr - 1'b1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        step_cnt_d  = '0;
        sym_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        sym_ready_d = 1'b1;
        acs_en_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sym_ready  <= 1'b1;
      acs_idx    <= '0;
      acs_en     <= 1'b0;
      step_cnt   <= '0;
      tb_addr    <= '0;
      tb_state   <= '0;
      dec_bit    <= 1'b0;
      dec_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sym_ready  <= sym_ready_d;
      acs_idx    <= acs_idx_d;
      acs_en     <= acs_en_d;
      step_cnt   <= step_cnt_d;
      tb_addr    <= tb_addr_d;
      tb_state   <= tb_state_d;
      dec_bit    <= dec_bit_d;
      dec_valid  <= dec_valid_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule
